// File: rtl/axi4_lite_data_memory.sv
// AXI4-Lite responder holding 16-bit data words behind byte addresses.
// One transaction at a time, writes win over reads, registered responses.
module axi4_lite_data_memory #(
  parameter int WORD_ADDR_WIDTH = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [2:0]  S_AXI_AWPROT,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [2:0]  S_AXI_ARPROT,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ACC,
    S_WR_RESP,
    S_RD_ACC,
    S_RD_RESP
  } state_t;

  state_t r_state, w_next;

  logic [15:0] r_mem [2**WORD_ADDR_WIDTH];

  logic        r_aw_got, r_w_got;
  logic [31:0] r_awaddr;
  logic [15:0] r_wdata;
  logic [1:0]  r_wstrb;
  logic [1:0]  r_bresp;
  logic [15:0] r_rdata;
  logic [1:0]  r_rresp;

  logic        w_aw_hs, w_w_hs;
  logic        w_aw_have, w_w_have;
  logic        w_commit, w_rd_take;
  logic [31:0] w_awaddr;
  logic [15:0] w_wdata;
  logic [1:0]  w_wstrb;
  logic        w_aw_ok, w_ar_ok;
  logic [WORD_ADDR_WIDTH-1:0] w_widx, w_ridx;
  logic        w_unused;

  // Payload comes from the latch if already taken, else straight off the bus
  assign w_aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_w_hs    = S_AXI_WVALID & S_AXI_WREADY;
  assign w_aw_have = r_aw_got | w_aw_hs;
  assign w_w_have  = r_w_got | w_w_hs;
  assign w_commit  = (r_state == S_WR_ACC) & w_aw_have & w_w_have;
  assign w_rd_take = (r_state == S_RD_ACC) & S_AXI_ARVALID;

  assign w_awaddr = r_aw_got ? r_awaddr : S_AXI_AWADDR;
  assign w_wdata  = r_w_got ? r_wdata : S_AXI_WDATA[15:0];
  assign w_wstrb  = r_w_got ? r_wstrb : S_AXI_WSTRB[1:0];

  assign w_aw_ok = ~|w_awaddr[31:WORD_ADDR_WIDTH+1];
  assign w_ar_ok = ~|S_AXI_ARADDR[31:WORD_ADDR_WIDTH+1];
  assign w_widx  = w_awaddr[WORD_ADDR_WIDTH:1];
  assign w_ridx  = S_AXI_ARADDR[WORD_ADDR_WIDTH:1];

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_WDATA[31:16], S_AXI_WSTRB[3:2],
                      w_awaddr[0], S_AXI_ARADDR[0]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (S_AXI_AWVALID | S_AXI_WVALID) w_next = S_WR_ACC;
        else if (S_AXI_ARVALID)           w_next = S_RD_ACC;
      end
      S_WR_ACC:  if (w_commit)     w_next = S_WR_RESP;
      S_WR_RESP: if (S_AXI_BREADY) w_next = S_IDLE;
      S_RD_ACC:  if (w_rd_take)    w_next = S_RD_RESP;
      S_RD_RESP: if (S_AXI_RREADY) w_next = S_IDLE;
      default:                     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = (r_state == S_WR_ACC) & ~r_aw_got;
    S_AXI_WREADY  = (r_state == S_WR_ACC) & ~r_w_got;
    S_AXI_BVALID  = (r_state == S_WR_RESP);
    S_AXI_ARREADY = (r_state == S_RD_ACC);
    S_AXI_RVALID  = (r_state == S_RD_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_bresp  <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (w_aw_hs) begin
        r_aw_got <= 1'b1;
        r_awaddr <= S_AXI_AWADDR;
      end
      if (w_w_hs) begin
        r_w_got <= 1'b1;
        r_wdata <= S_AXI_WDATA[15:0];
        r_wstrb <= S_AXI_WSTRB[1:0];
      end
    end
  end

  // Contents survive reset; a reset edge still blocks a pending commit
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_aw_ok) begin
      if (w_wstrb[0]) r_mem[w_widx][7:0]  <= w_wdata[7:0];
      if (w_wstrb[1]) r_mem[w_widx][15:8] <= w_wdata[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_rd_take) begin
      r_rdata <= w_ar_ok ? r_mem[w_ridx] : 16'h0000;
      r_rresp <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign S_AXI_BRESP = r_bresp;
  assign S_AXI_RDATA = {16'h0000, r_rdata};
  assign S_AXI_RRESP = r_rresp;

endmodule

// File: doc/axi4_lite_data_memory.md
Name: axi4_lite_data_memory

Overview:
AXI4-Lite slave (responder) data memory. It answers the CPU's AXI4-Lite master at the MEM stage and replaces the former single-cycle data memory. It stores 16-bit words. AXI addresses are byte addresses, and data travels in the low half of the 32-bit data bus. It serves one transaction at a time, writes take priority over reads, and responses are fully registered.

Parameters:
WORD_ADDR_WIDTH, 15, number of word-index bits; depth = 2**WORD_ADDR_WIDTH 16-bit words (default covers a 64 KB byte space)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
S_AXI_AWADDR  in  32  write byte address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address accept
S_AXI_WDATA  in  32  write data; only [15:0] used
S_AXI_WSTRB  in  4  byte strobes; only [1:0] used
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data accept
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response accept
S_AXI_ARADDR  in  32  read byte address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address accept
S_AXI_RDATA  out  32  read data = {16'h0000, word}
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data accept

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst).
- Address decode:
  - word index = ADDR[WORD_ADDR_WIDTH:1]; ADDR[0] is ignored.
  - In range when ADDR[31:WORD_ADDR_WIDTH+1] == 0. Otherwise the response is SLVERR (2'b10): no memory update, RDATA = 0.
  - OKAY = 2'b00.
- State register: IDLE, WR_ACCEPT, WR_RESP, RD_ACCEPT, RD_RESP.
- All READY/VALID outputs are decoded from registered state only, with no combinational path from any input.
- IDLE (all READY and VALID low):
  - AWVALID | WVALID -> WR_ACCEPT.
  - Else ARVALID -> RD_ACCEPT.
  - Write wins when both are requested in the same cycle.
- WR_ACCEPT:
  - AWREADY = ~aw_got; WREADY = ~w_got.
  - Each handshake latches its payload and sets its got flag. AW and W may complete in either order or together.
  - On the edge where both are held, commit the write:
    - WSTRB[0] -> bits [7:0]; WSTRB[1] -> bits [15:8].
    - WSTRB == 0 commits nothing and still responds OKAY.
  - At the same edge: load BRESP, clear both got flags, go to WR_RESP.
- WR_RESP:
  - BVALID = 1; BRESP held stable.
  - BREADY -> IDLE.
- RD_ACCEPT:
  - ARREADY = 1.
  - On ARVALID: register word (or 0 for an out-of-range address) into RDATA and RRESP, then go to RD_RESP.
- RD_RESP:
  - RVALID = 1; RDATA and RRESP held stable until RREADY.
  - RREADY -> IDLE.
- Latency, counting the cycle the request is first presented in IDLE as cycle 0:
  - Write with AW and W together: READY at cycle 1, BVALID at cycle 2.
  - Read: ARREADY at cycle 1, RVALID at cycle 2.
  - Minimum turnaround between transactions: one IDLE cycle.
- Read-after-write: a read that follows a write sees the committed data, because the commit happens before WR_RESP.
- Reset:
  - Outputs: AWREADY, WREADY, ARREADY, BVALID and RVALID = 0; BRESP = RRESP = 2'b00; RDATA = 0.
  - State = IDLE; got flags cleared.
  - Memory contents are not cleared.
- Reset mid-operation:
  - A write not yet committed is discarded.
  - Pending responses are dropped.
  - The block returns to IDLE on the next edge.

Test Plan:
1. Write then read, AW and W together:
   - Stimulus: AWADDR=0x0000_0010, WDATA=0x0000_BEEF, WSTRB=4'b0011, then read ARADDR=0x10.
   - Response: AWREADY/WREADY at cycle 1, BVALID at cycle 2 with BRESP=00; RVALID with RDATA=0x0000_BEEF, RRESP=00.
2. Split write channels and byte strobes:
   - Stimulus: W (WDATA=0x1234, WSTRB=4'b0001) two cycles before AW (addr 0x20), over a word preloaded with 0xAAAA.
   - Response: single BVALID only after AW is accepted; readback = 0xAA34.
3. Simultaneous AWVALID+WVALID+ARVALID, same address 0x30, WDATA 0x5555:
   - Response: write is served first; the read is then accepted and returns 0x5555.
4. Out-of-range address, AWADDR=0x0001_0000:
   - Response: BRESP=2'b10 and memory unchanged. A read of 0x0001_0002 returns RRESP=2'b10, RDATA=0.
5. Back-pressure:
   - Stimulus: hold BREADY=0 (and, separately, RREADY=0) for 5 cycles.
   - Response: BVALID/RVALID and BRESP/RDATA stay stable; no new AWREADY/ARREADY until accepted.
6. Reset mid-operation:
   - Stimulus: assert rst after the AW handshake but before W.
   - Response: next cycle all VALID/READY are 0. A following read of that address returns the prior data (write discarded).
